// File: rtl/par_bridge_pkg.sv
// Shared types and configuration helpers for the parallel device bridge.
package par_bridge_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_e;

  function automatic bit cfg_ok(input int data_w, input int addr_w, input int setup_cyc,
                                input int strobe_cyc, input int hold_cyc, input int irq_n);
    return ((data_w == 8) || (data_w == 16) || (data_w == 32)) &&
           (addr_w >= 1) && (addr_w <= 24) &&
           (setup_cyc >= 0) && (setup_cyc <= 15) &&
           (strobe_cyc >= 1) && (strobe_cyc <= 15) &&
           (hold_cyc >= 0) && (hold_cyc <= 15) &&
           (irq_n >= 1) && (irq_n <= 8);
  endfunction

  // A phase of N cycles counts N-1 down to 0.
  function automatic logic [CNT_W-1:0] phase_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/par_dev_bridge_irq_sync.sv
// Two-flop synchroniser for the asynchronous device interrupt lines.
module irq_sync
  import par_bridge_pkg::*;
#(
  parameter int IRQ_N = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_N-1:0] irq_async,
  output logic [IRQ_N-1:0] irq_o
);

  logic [IRQ_N-1:0] meta_q, meta_d;
  logic [IRQ_N-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = irq_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign irq_o = sync_q;

endmodule

// File: rtl/par_dev_bridge.sv
// Bus-to-parallel-device bridge with programmable setup/strobe/hold timing.
// Define PAR_BRIDGE_POSTED_WR_EN to let writes complete on the bus immediately.
module par_dev_bridge
  import par_bridge_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int IRQ_N      = 1
) (
  input  logic              clk_bus,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [31:0]       bus_data_i,
  output logic [31:0]       bus_data_o,
  input  logic              bus_read,
  input  logic              bus_write,
  output logic              bus_stall,
  output logic [IRQ_N-1:0]  bus_irq,
  output logic [ADDR_W-1:0] dev_address,
  output logic [DATA_W-1:0] dev_data_o,
  input  logic [DATA_W-1:0] dev_data_i,
  output logic              dev_data_t,
  output logic              dev_we_n,
  output logic              dev_oe_n,
  output logic              dev_ce_n,
  input  logic [IRQ_N-1:0]  dev_irq,
  output logic              dev_rst_n
);

  if (!cfg_ok(DATA_W, ADDR_W, SETUP_CYC, STROBE_CYC, HOLD_CYC, IRQ_N)) begin : g_bad_cfg
    $error("par_dev_bridge: illegal parameter combination");
  end

  if (DATA_W < 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^bus_data_i[31:DATA_W];
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              data_t_q, data_t_d;
  logic              dev_rst_n_q, dev_rst_n_d;
  logic              req;

  assign req = bus_read | bus_write;

  // State and pin registers
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      data_t_q    <= 1'b1;
      dev_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      data_t_q    <= data_t_d;
      dev_rst_n_q <= dev_rst_n_d;
    end
  end

  // Next state: one shared down-counter, reloaded on every phase entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = bus_address;
          wdata_d = bus_data_i[DATA_W-1:0];
          wr_d    = bus_write;
          if (SETUP_CYC > 0) begin
            state_d = ST_SETUP;
            cnt_d   = phase_load(SETUP_CYC);
          end else begin
            state_d = ST_STROBE;
            cnt_d   = phase_load(STROBE_CYC);
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = phase_load(STROBE_CYC);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          if (!wr_q) rdata_d = dev_data_i;
          if (HOLD_CYC > 0) begin
            state_d = ST_HOLD;
            cnt_d   = phase_load(HOLD_CYC);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin outputs decoded from the next state so the pins come straight from flops
  always_comb begin
    ce_n_d      = 1'b1;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    data_t_d    = 1'b1;
    dev_rst_n_d = ~rst;
    case (state_d)
      ST_SETUP, ST_HOLD: begin
        ce_n_d   = 1'b0;
        data_t_d = ~wr_d;
      end
      ST_STROBE: begin
        ce_n_d   = 1'b0;
        we_n_d   = ~wr_d;
        oe_n_d   = wr_d;
        data_t_d = ~wr_d;
      end
      default: ;
    endcase
  end

`ifdef PAR_BRIDGE_POSTED_WR_EN
  logic posted_q, posted_d;

  always_comb begin
    posted_d = posted_q;
    if (state_q == ST_IDLE) posted_d = bus_write;
  end

  always_ff @(posedge clk_bus) begin
    if (rst) posted_q <= 1'b0;
    else     posted_q <= posted_d;
  end

  // A posted write's DONE belongs to no waiting master, so a new request keeps stalling.
  always_comb begin
    bus_stall = req & (state_q != ST_DONE);
    if ((state_q == ST_IDLE) && bus_write && !rst) bus_stall = 1'b0;
    if ((state_q == ST_DONE) && posted_q)         bus_stall = req;
  end
`else
  always_comb begin
    bus_stall = req & (state_q != ST_DONE);
  end
`endif

  irq_sync #(
    .IRQ_N(IRQ_N)
  ) u_irq_sync (
    .clk      (clk_bus),
    .rst      (rst),
    .irq_async(dev_irq),
    .irq_o    (bus_irq)
  );

  assign bus_data_o  = 32'(rdata_q);
  assign dev_address = addr_q;
  assign dev_data_o  = wdata_q;
  assign dev_data_t  = data_t_q;
  assign dev_we_n    = we_n_q;
  assign dev_oe_n    = oe_n_q;
  assign dev_ce_n    = ce_n_q;
  assign dev_rst_n   = dev_rst_n_q;

endmodule

// File: tb/tb_par_dev_bridge.sv
// Directed scoreboard bench for par_dev_bridge: a default-timing 16-bit instance and a fast 8-bit instance.
module tb_par_dev_bridge;

`ifdef PAR_BRIDGE_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        rd, wr, sel;
  logic [15:0] dev_rdata;
  logic [2:0]  a_irq_in;
  logic        b_irq_in;

  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_bus_data_o, b_bus_data_o;
  logic        a_stall, b_stall;
  logic [2:0]  a_bus_irq;
  logic        b_bus_irq;
  logic [2:0]  a_dev_addr, b_dev_addr;
  logic [15:0] a_dev_do;
  logic [7:0]  b_dev_do;
  logic        a_dt, a_we_n, a_oe_n, a_ce_n, a_rst_n;
  logic        b_dt, b_we_n, b_oe_n, b_ce_n, b_rst_n;

  logic        m_stall, m_ce, m_we, m_oe, m_dt;
  logic [2:0]  m_addr;
  logic [31:0] m_wd, m_rd;

  int n_err = 0;
  int n_checks = 0;
  int hi_run = 0;
  int last_gap = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign a_read  = rd & ~sel;
  assign a_write = wr & ~sel;
  assign b_read  = rd & sel;
  assign b_write = wr & sel;

  par_dev_bridge #(
    .DATA_W(16), .ADDR_W(3), .SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1), .IRQ_N(3)
  ) u_a (
    .clk_bus(clk), .rst(rst), .bus_address(addr), .bus_data_i(wdata), .bus_data_o(a_bus_data_o),
    .bus_read(a_read), .bus_write(a_write), .bus_stall(a_stall), .bus_irq(a_bus_irq),
    .dev_address(a_dev_addr), .dev_data_o(a_dev_do), .dev_data_i(dev_rdata), .dev_data_t(a_dt),
    .dev_we_n(a_we_n), .dev_oe_n(a_oe_n), .dev_ce_n(a_ce_n), .dev_irq(a_irq_in), .dev_rst_n(a_rst_n)
  );

  par_dev_bridge #(
    .DATA_W(8), .ADDR_W(3), .SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0), .IRQ_N(1)
  ) u_b (
    .clk_bus(clk), .rst(rst), .bus_address(addr), .bus_data_i(wdata), .bus_data_o(b_bus_data_o),
    .bus_read(b_read), .bus_write(b_write), .bus_stall(b_stall), .bus_irq(b_bus_irq),
    .dev_address(b_dev_addr), .dev_data_o(b_dev_do), .dev_data_i(dev_rdata[7:0]), .dev_data_t(b_dt),
    .dev_we_n(b_we_n), .dev_oe_n(b_oe_n), .dev_ce_n(b_ce_n), .dev_irq(b_irq_in), .dev_rst_n(b_rst_n)
  );

  always_comb begin
    if (sel) begin
      m_stall = b_stall; m_ce = b_ce_n; m_we = b_we_n; m_oe = b_oe_n; m_dt = b_dt;
      m_addr = b_dev_addr; m_wd = {24'h0, b_dev_do}; m_rd = b_bus_data_o;
    end else begin
      m_stall = a_stall; m_ce = a_ce_n; m_we = a_we_n; m_oe = a_oe_n; m_dt = a_dt;
      m_addr = a_dev_addr; m_wd = {16'h0, a_dev_do}; m_rd = a_bus_data_o;
    end
  end

  // Length of the CE_n-high run preceding the most recent device cycle
  always @(negedge clk) begin
    if (m_ce) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run > 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  // Runs one bus transaction; entered and left just after a rising edge.
  task automatic run_txn(input bit s, input bit w, input bit both, input logic [2:0] a,
                         input logic [31:0] d, input logic [15:0] rdev, input int setup_c,
                         input int strobe_c, input int hold_c, input logic [31:0] dmask);
    int  cyc = 0, lat = -1, ce_cnt = 0, pre = 0, stb = 0, bad_stb = 0;
    int  dt_low = 0, addr_err = 0, wd_err = 0;
    bit  seen = 0, started = 0, fin = 0;
    logic dt_at_done = 1'b0;
    logic [31:0] rd_at_done = '0;
    sb_push("latency", 32'((POSTED && w) ? 0 : 1 + setup_c + strobe_c + hold_c));
    sb_push("ce_low_cycles", 32'(setup_c + strobe_c + hold_c));
    sb_push("setup_cycles", 32'(setup_c));
    sb_push("strobe_low_cycles", 32'(strobe_c));
    sb_push("wrong_strobe_cycles", 32'd0);
    sb_push("data_driven_cycles", 32'(w ? setup_c + strobe_c + hold_c : 0));
    sb_push("address_errors", 32'd0);
    sb_push("wdata_errors", 32'd0);
    sb_push("data_t_in_done", 32'd1);
    if (!w) sb_push("read_data", {16'h0, rdev} & dmask);
    sel = s; addr = a; wdata = d; dev_rdata = rdev;
    rd = !w || both; wr = w;
    while (!fin && cyc < 64) begin
      @(negedge clk);
      if (!m_ce) begin
        ce_cnt++;
        started = 1;
        if (m_addr !== a) addr_err++;
        if (w && (m_wd !== (d & dmask))) wd_err++;
        if (!m_dt) dt_low++;
        if ((w ? m_we : m_oe) == 1'b0) stb++;
        else if (stb == 0) pre++;
        if ((w ? m_oe : m_we) == 1'b0) bad_stb++;
      end
      if (!m_stall && !seen) begin
        seen = 1;
        lat = cyc;
      end
      if (seen && started && m_ce) begin
        fin = 1;
        dt_at_done = m_dt;
        rd_at_done = m_rd;
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (seen) begin rd = 1'b0; wr = 1'b0; end
      end
    end
    if (!fin) check("transaction_timeout", 32'(cyc), 32'd0);
    sb_pop(32'(lat));
    sb_pop(32'(ce_cnt));
    sb_pop(32'(pre));
    sb_pop(32'(stb));
    sb_pop(32'(bad_stb));
    sb_pop(32'(dt_low));
    sb_pop(32'(addr_err));
    sb_pop(32'(wd_err));
    sb_pop(32'(dt_at_done));
    if (!w) sb_pop(rd_at_done);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first, hi, bad, n1, n2, n3;
    bit  found;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
    dev_rdata = '0; a_irq_in = '0; b_irq_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", 32'(a_stall), 32'd0);
    check("rst_bus_data_o", a_bus_data_o, 32'd0);
    check("rst_bus_irq", 32'(a_bus_irq), 32'd0);
    check("rst_dev_address", 32'(a_dev_addr), 32'd0);
    check("rst_dev_data_o", 32'(a_dev_do), 32'd0);
    check("rst_dev_data_t", 32'(a_dt), 32'd1);
    check("rst_we_n", 32'(a_we_n), 32'd1);
    check("rst_oe_n", 32'(a_oe_n), 32'd1);
    check("rst_ce_n", 32'(a_ce_n), 32'd1);
    check("rst_dev_rst_n", 32'(a_rst_n), 32'd0);
    check("rst_b_dev_rst_n", 32'(b_rst_n), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("dev_rst_n_still_low", 32'(a_rst_n), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("dev_rst_n_released", 32'(a_rst_n), 32'd1);
    @(posedge clk); #1;

    // Default timing: read, then a write that must not disturb the held read data
    run_txn(1'b0, 1'b0, 1'b0, 3'd3, 32'h0, 16'hBEEF, 1, 3, 1, 32'h0000FFFF);
    run_txn(1'b0, 1'b1, 1'b0, 3'd5, 32'h12345678, 16'h0, 1, 3, 1, 32'h0000FFFF);
    check("read_data_held", a_bus_data_o, 32'h0000BEEF);

    // Fast 8-bit instance: narrow write, read+write treated as write, back-to-back reads
    run_txn(1'b1, 1'b1, 1'b0, 3'd5, 32'h12345678, 16'h0, 0, 1, 0, 32'h000000FF);
    run_txn(1'b1, 1'b1, 1'b1, 3'd6, 32'hAABBCC3C, 16'h0, 0, 1, 0, 32'h000000FF);
    run_txn(1'b1, 1'b0, 1'b0, 3'd2, 32'h0, 16'h77A5, 0, 1, 0, 32'h000000FF);
    run_txn(1'b1, 1'b0, 1'b0, 3'd6, 32'h0, 16'h005A, 0, 1, 0, 32'h000000FF);
    check("b2b_ce_high_gap", 32'(last_gap), 32'd2);

    // Reset landing in the strobe phase of a write
    sel = 1'b0; addr = 3'd1; wdata = 32'h0000CAFE; wr = 1'b1; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (!a_we_n) found = 1;
      else begin @(posedge clk); #1; end
    end
    check("reach_write_strobe", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ce_n", 32'(a_ce_n), 32'd1);
    check("midrst_we_n", 32'(a_we_n), 32'd1);
    check("midrst_oe_n", 32'(a_oe_n), 32'd1);
    check("midrst_data_t", 32'(a_dt), 32'd1);
    check("midrst_dev_rst_n", 32'(a_rst_n), 32'd0);
    check("midrst_stall_held_req", 32'(a_stall), 32'd1);
    wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n1 = 0; n2 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!a_ce_n) n1++;
      if (a_stall) n2++;
    end
    check("postrst_no_device_cycle", 32'(n1), 32'd0);
    check("postrst_stall_low", 32'(n2), 32'd0);
    check("postrst_dev_address", 32'(a_dev_addr), 32'd0);

    // Interrupt pulse of 4 clocks on lines 0 and 2
    @(posedge clk); #3;
    a_irq_in = 3'b101;
    first = -1; hi = 0; bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_bus_irq === 3'b101) begin
        if (first < 0) first = k;
        hi++;
      end else if (a_bus_irq !== 3'b000) begin
        bad++;
      end
      if (k == 3) begin @(posedge clk); #3; a_irq_in = 3'b000; end
    end
    check("irq_latency_2_to_3", 32'((first >= 2) && (first <= 3)), 32'd1);
    check("irq_high_cycles", 32'(hi), 32'd4);
    check("irq_bad_values", 32'(bad), 32'd0);
    @(posedge clk); #1;

`ifdef PAR_BRIDGE_POSTED_WR_EN
    // Posted write immediately followed by a read
    sb_push("posted_wr_stall", 32'd0);
    sb_push("read_behind_post_stall", 32'd12);
    sb_push("read_ce_gap", 32'd2);
    sb_push("read_after_post_data", 32'h00002468);
    sel = 1'b0; addr = 3'd4; wdata = 32'h00001357; wr = 1'b1;
    @(negedge clk);
    sb_pop(32'(a_stall));
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b1; addr = 3'd2; dev_rdata = 16'h2468;
    n3 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!a_stall) break;
      n3++;
    end
    sb_pop(32'(n3));
    sb_pop(32'(last_gap));
    sb_pop(a_bus_data_o);
    @(posedge clk); #1;
    rd = 1'b0;
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
